apu_pulse_sequencer: RTL and testbench
======================================

Name: apu_pulse_sequencer

Overview:
Autonomous note sequencer that drives the configuration channels of the APU pulse channel: the 11-bit period stream and the 2-bit duty stream. A small step table holds up to DEPTH steps of {period, duty, duration}. After start, the block pushes each step's period and duty over valid/ready handshakes, then holds that step for `duration` frame ticks. A free-running frame divider generates the frame ticks. The block sits between the host/program logic and the pulse channel's period/duty inputs; the pulse channel's output stream is not touched.

Parameters:
DEPTH, 16, number of step-table entries (power of two, >=2)
FRAME_DIV, 7457, clock cycles per frame tick (>=2)

Ports:
clk  in  1  single clock
reset  in  1  asynchronous, active-high reset
prog_wr_en  in  1  step-table write strobe
prog_addr  in  $clog2(DEPTH)  step-table write index
prog_data  in  21  {duration[7:0], duty[1:0], period[10:0]}; bits [20:13] duration, [12:11] duty, [10:0] period
start  in  1  single-cycle pulse; begins playback at step 0
stop  in  1  single-cycle pulse; abort playback
loop_en  in  1  1 = wrap to step 0 at end of sequence
period_r  out  11  period to pulse channel
period_r_vld  out  1  period valid
period_r_rdy  in  1  period ready
duty_r  out  2  duty to pulse channel
duty_r_vld  out  1  duty valid
duty_r_rdy  in  1  duty ready
busy  out  1  high in any state other than IDLE
step_idx  out  $clog2(DEPTH)  index of the current step
done  out  1  one-cycle pulse when playback ends, by end-of-sequence or stop

Behaviour:
- Interface: one clock, `clk`. Reset is asynchronous and active-high, on port `reset`.
- Reset values:
  - all outputs 0: period_r, duty_r, both vld, busy, step_idx, done.
  - FSM = IDLE; frame counter = 0; step-table entries = 0. An all-zero entry is an end marker.
- Frame divider:
  - free-running 0..FRAME_DIV-1 from reset, independent of FSM state.
  - frame_tick is high for the one cycle in which count == FRAME_DIV-1.
- Step-table write:
  - a write is accepted every cycle that prog_wr_en=1, in any state.
  - the entry is read combinationally at step load, so a write to the active entry affects only later loads of that entry.
- End marker: an entry with duration == 0.
- FSM states: IDLE, SEND, WAIT, NEXT.
- IDLE:
  - start=1 and stop=0: read entry 0. If it is an end marker, pulse done and stay in IDLE. Otherwise latch period_r/duty_r, assert both vld, set rem = duration, step_idx = 0, go to SEND.
  - start together with stop: stop wins, no action.
- SEND:
  - each vld deasserts in the cycle after its own vld&rdy handshake. The two channels complete independently, in any order or in the same cycle.
  - period_r/duty_r are stable while the corresponding vld is high.
  - when both handshakes are complete, go to WAIT.
  - the minimum SEND residency is 1 cycle, when both rdy are high on entry.
- WAIT:
  - on frame_tick: if rem == 1 go to NEXT, else rem--.
  - a duration of N therefore holds the step for N ticks; the first tick may be partial.
- NEXT (1 cycle): compute nxt = step_idx+1.
  - if step_idx == DEPTH-1 or entry[nxt] is an end marker:
    - loop_en=1 and entry 0 is not an end marker: load entry 0, go to SEND.
    - otherwise: pulse done, go to IDLE.
  - otherwise: load entry[nxt], step_idx = nxt, go to SEND.
- stop:
  - in WAIT or NEXT: go to IDLE next cycle, pulse done.
  - in SEND: latched as stop_pend. Vld is never withdrawn before its handshake; once both handshakes complete, go to IDLE and pulse done instead of WAIT.
  - ignored in IDLE.
- start while busy is ignored.
- Reset mid-operation: immediate return to reset values, including dropping vld mid-handshake. The pulse channel shares the same reset.
- The block never issues a new period/duty pair while a previous vld is still pending.

Decomposition:
- Shared package apu_pkg:
  - PERIOD_W=11, DUTY_W=2, DUR_W=8.
  - step_t struct {dur, duty, period}.
  - FSM state enum.
  - NES frame-divider constant 7457.
- One natural sub-module: apu_frame_divider (parameter FRAME_DIV; ports clk, reset, frame_tick).
- Step table and FSM remain in apu_pulse_sequencer.

Test Plan:
- Reset check: assert reset mid-SEND -> all outputs 0 immediately, without waiting for a clock edge; after release, busy=0.
- Single step:
  - setup: FRAME_DIV=4; entry0 = {dur 2, duty 2, period 0x1FD}; entry1 dur 0; both rdy=1.
  - start -> next cycle period_r=0x1FD, duty_r=2, both vld=1 for 1 cycle.
  - then WAIT for 2 ticks -> done pulse, busy=0.
- Backpressure: duty_rdy=0 for 5 cycles while period_rdy=1 -> period_vld drops after 1 cycle; duty_vld holds value 2 stable until rdy rises; FSM enters WAIT only after the duty handshake.
- Three steps with loop_en=1 -> steps 0,1,2,0,1... are pushed in order and step_idx wraps. Clear loop_en -> done after step 2.
- Stop in SEND with both rdy=0 -> vld stays high. Raise rdy -> both handshakes complete, then done pulse and IDLE, with no WAIT entered.
- Edge cases:
  - start together with stop in IDLE -> no activity.
  - entry0 is an end marker -> done one cycle after start, busy stays 0.
  - DEPTH-1 entries all valid, loop_en=0 -> done after the last entry.

Source files
------------

// File: rtl/apu_pkg.sv
// rtl/apu_pkg.sv - shared widths, step record and FSM states for the APU pulse sequencer
package apu_pkg;
  localparam int PERIOD_W      = 11;
  localparam int DUTY_W        = 2;
  localparam int DUR_W         = 8;
  localparam int STEP_W        = DUR_W + DUTY_W + PERIOD_W;
  localparam int NES_FRAME_DIV = 7457;

  // Field order matches the prog_data layout so a write is a plain cast
  typedef struct packed {
    logic [DUR_W-1:0]    dur;
    logic [DUTY_W-1:0]   duty;
    logic [PERIOD_W-1:0] period;
  } step_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT,
    ST_NEXT
  } seq_state_t;

  function automatic logic is_end_marker(input step_t s);
    return (s.dur == '0);
  endfunction
endpackage

// File: rtl/apu_pulse_sequencer_if.sv
// rtl/apu_pulse_sequencer_if.sv - period/duty configuration handshakes toward the pulse channel
interface apu_pulse_sequencer_if;
  import apu_pkg::*;

  logic [PERIOD_W-1:0] period_r;
  logic                period_r_vld;
  logic                period_r_rdy;
  logic [DUTY_W-1:0]   duty_r;
  logic                duty_r_vld;
  logic                duty_r_rdy;

  modport master (
    output period_r, period_r_vld, duty_r, duty_r_vld,
    input  period_r_rdy, duty_r_rdy
  );

  modport slave (
    input  period_r, period_r_vld, duty_r, duty_r_vld,
    output period_r_rdy, duty_r_rdy
  );
endinterface

// File: rtl/apu_frame_divider.sv
// rtl/apu_frame_divider.sv - free-running frame tick generator, one tick every FRAME_DIV cycles
module apu_frame_divider #(
  parameter int FRAME_DIV = apu_pkg::NES_FRAME_DIV
) (
  input  logic clk,
  input  logic reset,
  output logic frame_tick
);
  localparam int CW = $clog2(FRAME_DIV);

  logic [CW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap     = (r_cnt == CW'(FRAME_DIV - 1));
  assign frame_tick = w_wrap;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       r_cnt <= '0;
    else if (w_wrap) r_cnt <= '0;
    else             r_cnt <= r_cnt + 1'b1;
  end
endmodule

// File: rtl/apu_pulse_sequencer.sv
// rtl/apu_pulse_sequencer.sv - step-table player pushing period/duty pairs, holding each for N frame ticks
module apu_pulse_sequencer
  import apu_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int FRAME_DIV = NES_FRAME_DIV
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     prog_wr_en,
  input  logic [$clog2(DEPTH)-1:0] prog_addr,
  input  logic [STEP_W-1:0]        prog_data,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     loop_en,
  apu_pulse_sequencer_if.master    cfg,
  output logic                     busy,
  output logic [$clog2(DEPTH)-1:0] step_idx,
  output logic                     done
);
  localparam int AW = $clog2(DEPTH);

  step_t               r_table [DEPTH];
  seq_state_t          r_state, w_state_nxt;
  logic [PERIOD_W-1:0] r_period, w_period_nxt;
  logic [DUTY_W-1:0]   r_duty, w_duty_nxt;
  logic                r_pvld, w_pvld_nxt;
  logic                r_dvld, w_dvld_nxt;
  logic [DUR_W-1:0]    r_rem, w_rem_nxt;
  logic [AW-1:0]       r_idx, w_idx_nxt;
  logic                r_done, w_done_nxt;
  logic                r_stop_pend, w_stop_pend_nxt;

  logic                w_frame_tick;
  logic                w_load;
  step_t               w_ld_entry;
  logic [AW-1:0]       w_ld_idx;
  logic [AW-1:0]       w_nxt_idx;
  step_t               w_nxt_entry;
  logic                w_p_ok, w_d_ok, w_stop_any;

  apu_frame_divider #(.FRAME_DIV(FRAME_DIV)) u_frame_div (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (w_frame_tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_table[i] <= '0;
    end else if (prog_wr_en) begin
      r_table[prog_addr] <= step_t'(prog_data);
    end
  end

  assign w_nxt_idx   = r_idx + 1'b1;
  assign w_nxt_entry = r_table[w_nxt_idx];
  // A channel is finished once its vld is already low or handshakes this cycle
  assign w_p_ok      = !r_pvld || cfg.period_r_rdy;
  assign w_d_ok      = !r_dvld || cfg.duty_r_rdy;
  assign w_stop_any  = stop || r_stop_pend;

  always_comb begin
    w_state_nxt     = r_state;
    w_period_nxt    = r_period;
    w_duty_nxt      = r_duty;
    w_pvld_nxt      = r_pvld;
    w_dvld_nxt      = r_dvld;
    w_rem_nxt       = r_rem;
    w_idx_nxt       = r_idx;
    w_done_nxt      = 1'b0;
    w_stop_pend_nxt = r_stop_pend;
    w_load          = 1'b0;
    w_ld_entry      = r_table[0];
    w_ld_idx        = '0;

    case (r_state)
      ST_IDLE: begin
        if (start && !stop) begin
          if (is_end_marker(r_table[0])) w_done_nxt = 1'b1;
          else                           w_load     = 1'b1;
        end
      end
      ST_SEND: begin
        w_pvld_nxt      = r_pvld && !cfg.period_r_rdy;
        w_dvld_nxt      = r_dvld && !cfg.duty_r_rdy;
        w_stop_pend_nxt = w_stop_any;
        if (w_p_ok && w_d_ok) begin
          if (w_stop_any) begin
            w_state_nxt     = ST_IDLE;
            w_done_nxt      = 1'b1;
            w_stop_pend_nxt = 1'b0;
          end else begin
            w_state_nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (stop) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end else if (w_frame_tick) begin
          if (r_rem == DUR_W'(1)) w_state_nxt = ST_NEXT;
          else                    w_rem_nxt   = r_rem - 1'b1;
        end
      end
      ST_NEXT: begin
        if (stop) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end else if (r_idx == AW'(DEPTH - 1) || is_end_marker(w_nxt_entry)) begin
          if (loop_en && !is_end_marker(r_table[0])) begin
            w_load = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
          end
        end else begin
          w_load     = 1'b1;
          w_ld_entry = w_nxt_entry;
          w_ld_idx   = w_nxt_idx;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if (w_load) begin
      w_period_nxt    = w_ld_entry.period;
      w_duty_nxt      = w_ld_entry.duty;
      w_pvld_nxt      = 1'b1;
      w_dvld_nxt      = 1'b1;
      w_rem_nxt       = w_ld_entry.dur;
      w_idx_nxt       = w_ld_idx;
      w_stop_pend_nxt = 1'b0;
      w_state_nxt     = ST_SEND;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_period    <= '0;
      r_duty      <= '0;
      r_pvld      <= 1'b0;
      r_dvld      <= 1'b0;
      r_rem       <= '0;
      r_idx       <= '0;
      r_done      <= 1'b0;
      r_stop_pend <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_period    <= w_period_nxt;
      r_duty      <= w_duty_nxt;
      r_pvld      <= w_pvld_nxt;
      r_dvld      <= w_dvld_nxt;
      r_rem       <= w_rem_nxt;
      r_idx       <= w_idx_nxt;
      r_done      <= w_done_nxt;
      r_stop_pend <= w_stop_pend_nxt;
    end
  end

  assign cfg.period_r     = r_period;
  assign cfg.period_r_vld = r_pvld;
  assign cfg.duty_r       = r_duty;
  assign cfg.duty_r_vld   = r_dvld;
  assign busy             = (r_state != ST_IDLE);
  assign step_idx         = r_idx;
  assign done             = r_done;
endmodule

// File: tb/tb_apu_pulse_sequencer.sv
// tb/tb_apu_pulse_sequencer.sv - directed and randomized bench with a timeline reference model
module tb_apu_pulse_sequencer;
  import apu_pkg::*;

  localparam int DEPTH = 4;
  localparam int FD    = 4;
  localparam int AW    = 2;

  typedef struct {int cyc; int val; int idx;} ev_t;
  typedef struct {int cyc; int period; int duty; int idx;} xp_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              prog_wr_en = 1'b0;
  logic [AW-1:0]     prog_addr = '0;
  logic [STEP_W-1:0] prog_data = '0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              loop_en = 1'b0;
  logic              busy;
  logic [AW-1:0]     step_idx;
  logic              done;

  int    n_chk = 0;
  int    n_bad = 0;
  int    cyc = 0;
  int    s, dc, n, exp_done;
  ev_t   pe, de;
  ev_t   p_q[$];
  ev_t   d_q[$];
  xp_t   exp_q[$];
  step_t tbl [DEPTH];

  apu_pulse_sequencer_if ch();

  apu_pulse_sequencer #(.DEPTH(DEPTH), .FRAME_DIV(FD)) dut (
    .clk        (clk),
    .reset      (reset),
    .prog_wr_en (prog_wr_en),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .start      (start),
    .stop       (stop),
    .loop_en    (loop_en),
    .cfg        (ch),
    .busy       (busy),
    .step_idx   (step_idx),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Cycle number since reset release; the frame tick falls in cycles where cyc % FD == FD-1
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (ch.period_r_vld && ch.period_r_rdy) begin
        pe.cyc = cyc; pe.val = int'(ch.period_r); pe.idx = int'(step_idx);
        p_q.push_back(pe);
      end
      if (ch.duty_r_vld && ch.duty_r_rdy) begin
        de.cyc = cyc; de.val = int'(ch.duty_r); de.idx = int'(step_idx);
        d_q.push_back(de);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input int a, input int dur, input int duty, input int period);
    prog_wr_en = 1'b1;
    prog_addr  = a[AW-1:0];
    prog_data  = {dur[7:0], duty[1:0], period[10:0]};
    tbl[a]     = step_t'(prog_data);
    step();
    prog_wr_en = 1'b0;
  endtask

  task automatic pulse_start(output int sc);
    sc    = cyc;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic clear_mon();
    p_q.delete();
    d_q.delete();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_period"}, 32'(ch.period_r), 0);
    chk({tag, "_duty"},   32'(ch.duty_r), 0);
    chk({tag, "_pvld"},   32'(ch.period_r_vld), 0);
    chk({tag, "_dvld"},   32'(ch.duty_r_vld), 0);
    chk({tag, "_busy"},   32'(busy), 0);
    chk({tag, "_idx"},    32'(step_idx), 0);
    chk({tag, "_done"},   32'(done), 0);
  endtask

  function automatic int next_tick(input int k);
    return k + (FD - 1) - (k % FD);
  endfunction

  // Timeline model with both rdy held high: push, hold dur ticks counted from the
  // cycle after the push, then one cycle to decide, then the next push or done.
  function automatic void model_play(input int sc, input bit lp, input int maxp);
    int c, i, t, ni;
    exp_q.delete();
    c        = sc + 1;
    exp_done = sc + 1;
    if (tbl[0].dur == 0) return;
    i = 0;
    for (int guard = 0; guard < 64; guard++) begin
      xp_t x;
      x.cyc = c; x.period = int'(tbl[i].period); x.duty = int'(tbl[i].duty); x.idx = i;
      exp_q.push_back(x);
      t  = next_tick(c + 1) + FD * (int'(tbl[i].dur) - 1);
      c  = t + 2;
      ni = i + 1;
      if (ni == DEPTH || tbl[ni].dur == 0) begin
        if (lp && exp_q.size() < maxp) begin
          ni = 0;
        end else begin
          exp_done = c;
          return;
        end
      end
      i = ni;
    end
  endfunction

  task automatic wait_done(input string tag, input int budget, output int dcyc);
    dcyc = -1;
    for (int i = 0; i < budget; i++) begin
      step();
      if (done === 1'b1) begin
        dcyc = cyc;
        break;
      end
    end
    chk({tag, "_done_seen"}, 32'(dcyc >= 0), 1);
  endtask

  task automatic check_play(input string tag, input int dcyc);
    chk({tag, "_npush_p"}, p_q.size(), exp_q.size());
    chk({tag, "_npush_d"}, d_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k < p_q.size()) begin
        chk({tag, "_period"},   p_q[k].val, exp_q[k].period);
        chk({tag, "_push_cyc"}, p_q[k].cyc, exp_q[k].cyc);
        chk({tag, "_idx"},      p_q[k].idx, exp_q[k].idx);
      end
      if (k < d_q.size()) begin
        chk({tag, "_duty"},     d_q[k].val, exp_q[k].duty);
        chk({tag, "_duty_cyc"}, d_q[k].cyc, exp_q[k].cyc);
      end
    end
    chk({tag, "_done_cyc"}, dcyc, exp_done);
  endtask

  initial begin
    ch.period_r_rdy = 1'b0;
    ch.duty_r_rdy   = 1'b0;
    for (int a = 0; a < DEPTH; a++) tbl[a] = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk_zero("reset");

    // single step
    ch.period_r_rdy = 1'b1;
    ch.duty_r_rdy   = 1'b1;
    write_entry(0, 2, 2, 'h1FD);
    write_entry(1, 0, 1, 'h123);
    clear_mon();
    pulse_start(s);
    model_play(s, 1'b0, 0);
    chk("single_period", 32'(ch.period_r), 'h1FD);
    chk("single_duty",   32'(ch.duty_r), 2);
    chk("single_pvld",   32'(ch.period_r_vld), 1);
    chk("single_dvld",   32'(ch.duty_r_vld), 1);
    chk("single_busy",   32'(busy), 1);
    step();
    chk("single_pvld_off", 32'(ch.period_r_vld), 0);
    chk("single_dvld_off", 32'(ch.duty_r_vld), 0);
    chk("single_busy_wait", 32'(busy), 1);
    wait_done("single", 100, dc);
    check_play("single", dc);
    chk("single_busy_end", 32'(busy), 0);

    // duty backpressure for five cycles
    write_entry(0, 1, 2, 'h0AA);
    ch.duty_r_rdy = 1'b0;
    clear_mon();
    pulse_start(s);
    chk("bp_pvld_on", 32'(ch.period_r_vld), 1);
    chk("bp_dvld_on", 32'(ch.duty_r_vld), 1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("bp_pvld_low",  32'(ch.period_r_vld), 0);
      chk("bp_dvld_hold", 32'(ch.duty_r_vld), 1);
      chk("bp_duty_hold", 32'(ch.duty_r), 2);
    end
    step();
    ch.duty_r_rdy = 1'b1;
    chk("bp_dvld_last", 32'(ch.duty_r_vld), 1);
    step();
    chk("bp_dvld_off", 32'(ch.duty_r_vld), 0);
    wait_done("bp", 100, dc);
    chk("bp_done_cyc", dc, next_tick(s + 7) + 2);
    chk("bp_npush_d", d_q.size(), 1);

    // stop while both channels are stalled
    write_entry(0, 3, 1, 'h2C3);
    write_entry(1, 2, 3, 'h055);
    ch.period_r_rdy = 1'b0;
    ch.duty_r_rdy   = 1'b0;
    clear_mon();
    pulse_start(s);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop_pvld_held", 32'(ch.period_r_vld), 1);
    chk("stop_dvld_held", 32'(ch.duty_r_vld), 1);
    chk("stop_period",    32'(ch.period_r), 'h2C3);
    chk("stop_no_done",   32'(done), 0);
    step();
    step();
    ch.period_r_rdy = 1'b1;
    ch.duty_r_rdy   = 1'b1;
    step();
    chk("stop_done",     32'(done), 1);
    chk("stop_busy_off", 32'(busy), 0);
    chk("stop_pvld_off", 32'(ch.period_r_vld), 0);
    step();
    chk("stop_done_pulse", 32'(done), 0);
    repeat (20) step();
    chk("stop_npush", p_q.size(), 1);

    // start together with stop in IDLE
    clear_mon();
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("ss_busy", 32'(busy), 0);
      chk("ss_pvld", 32'(ch.period_r_vld), 0);
      chk("ss_done", 32'(done), 0);
      step();
    end
    chk("ss_npush", p_q.size(), 0);

    // entry 0 is an end marker
    write_entry(0, 0, 3, 'h7FF);
    clear_mon();
    pulse_start(s);
    chk("em_done", 32'(done), 1);
    chk("em_busy", 32'(busy), 0);
    chk("em_pvld", 32'(ch.period_r_vld), 0);
    step();
    chk("em_done_pulse", 32'(done), 0);

    // looping three-step sequence, loop cleared during the third pass
    write_entry(0, 1, 1, 'h101);
    write_entry(1, 2, 2, 'h202);
    write_entry(2, 1, 3, 'h303);
    write_entry(3, 0, 0, 'h000);
    loop_en = 1'b1;
    clear_mon();
    pulse_start(s);
    model_play(s, 1'b1, 9);
    for (int i = 0; i < 300 && p_q.size() < 7; i++) step();
    loop_en = 1'b0;
    wait_done("loop", 300, dc);
    check_play("loop", dc);

    // random tables: first DEPTH-1 valid entries, then a full table, then random lengths
    for (int it = 0; it < 6; it++) begin
      n = (it == 0) ? DEPTH - 1 : (it == 1) ? DEPTH : int'($urandom_range(1, DEPTH));
      for (int a = 0; a < DEPTH; a++) begin
        if (a < n) write_entry(a, int'($urandom_range(1, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 2047)));
        else       write_entry(a, 0, int'($urandom_range(0, 3)), int'($urandom_range(1, 2047)));
      end
      repeat ($urandom_range(0, 5)) step();
      clear_mon();
      pulse_start(s);
      model_play(s, 1'b0, 0);
      wait_done("rand", 300, dc);
      check_play("rand", dc);
    end

    // asynchronous reset in the middle of a handshake
    ch.period_r_rdy = 1'b0;
    ch.duty_r_rdy   = 1'b0;
    write_entry(0, 2, 1, 'h3AB);
    pulse_start(s);
    chk("rst_pre_pvld", 32'(ch.period_r_vld), 1);
    #2 reset = 1'b1;
    for (int a = 0; a < DEPTH; a++) tbl[a] = '0;
    #1 chk_zero("rst_async");
    step();
    reset = 1'b0;
    step();
    chk("rst_busy", 32'(busy), 0);
    ch.period_r_rdy = 1'b1;
    ch.duty_r_rdy   = 1'b1;
    clear_mon();
    pulse_start(s);
    model_play(s, 1'b0, 0);
    chk("rst_tbl_done", 32'(done), 1);
    chk("rst_tbl_cyc",  cyc, exp_done);
    chk("rst_tbl_busy", 32'(busy), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
